// File: rtl/rng_stream_if.sv
// Handshake bundle between the random-word source and its consumer.
// The master side is the generator; the slave side seeds, stalls and reads it.
interface rng_stream_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
);
  logic             loadseed_i;
  logic [WIDTH-1:0] seed_i;
  logic             ready_i;
  logic             valid_o;
  logic [WIDTH-1:0] number_o;
  logic             busy_o;
  logic [CNT_W-1:0] count_o;

  modport master (
    input  loadseed_i, seed_i, ready_i,
    output valid_o, number_o, busy_o, count_o
  );

  modport slave (
    output loadseed_i, seed_i, ready_i,
    input  valid_o, number_o, busy_o, count_o
  );
endinterface

// File: rtl/rng_stream.sv
// Galois LFSR random-word source with seed load, warm-up phase,
// zero-seed substitution, valid/ready output and delivered-word counter.
module rng_stream #(
  parameter int               WIDTH    = 64,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(64'hD800000000000000),
  parameter int               STEPS    = 1,
  parameter int               WARMUP   = 4,
  parameter logic [WIDTH-1:0] ZERO_SUB = '1,
  parameter int               CNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  rng_stream_if.master       bus
);

  localparam int WU_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [WU_W-1:0] WU_LAST = WU_W'((WARMUP > 0) ? WARMUP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_RUN
  } fsm_t;

  fsm_t             fsm_reg;
  logic [WIDTH-1:0] lfsr_reg;
  logic             valid_reg;
  logic             busy_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WU_W-1:0]  wu_cnt_reg;

  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] seed_value;
  logic             fire;

  // Unrolled step chain: stage gi+1 is one Galois right-shift step of stage gi.
  logic [WIDTH-1:0] step_chain [0:STEPS];

  assign step_chain[0] = lfsr_reg;

  generate
    for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
      assign step_chain[gi+1] = step_chain[gi][0]
                              ? ((step_chain[gi] >> 1) ^ TAPS)
                              : (step_chain[gi] >> 1);
    end
  endgenerate

  assign lfsr_next  = step_chain[STEPS];
  assign seed_value = (bus.seed_i == '0) ? ZERO_SUB : bus.seed_i;
  assign fire       = (fsm_reg == ST_RUN) && valid_reg && bus.ready_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_reg    <= ST_IDLE;
      lfsr_reg   <= '0;
      valid_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      count_reg  <= '0;
      wu_cnt_reg <= '0;
    end else if (bus.loadseed_i) begin
      // A load wins over a handshake on the same edge; that word is not counted.
      lfsr_reg   <= seed_value;
      count_reg  <= '0;
      wu_cnt_reg <= '0;
      valid_reg  <= 1'b0;
      if (WARMUP > 0) begin
        fsm_reg  <= ST_WARMUP;
        busy_reg <= 1'b1;
      end else begin
        fsm_reg  <= ST_RUN;
        busy_reg <= 1'b0;
      end
    end else begin
      case (fsm_reg)
        ST_IDLE: begin
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
        ST_WARMUP: begin
          lfsr_reg   <= lfsr_next;
          wu_cnt_reg <= wu_cnt_reg + 1'b1;
          if (wu_cnt_reg == WU_LAST) begin
            fsm_reg  <= ST_RUN;
            busy_reg <= 1'b0;
          end
        end
        ST_RUN: begin
          // First RUN cycle only raises valid; the word is offered from the next.
          if (!valid_reg) begin
            valid_reg <= 1'b1;
          end else if (fire) begin
            lfsr_reg  <= lfsr_next;
            count_reg <= count_reg + 1'b1;
          end
        end
        default: begin
          fsm_reg   <= ST_IDLE;
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.valid_o  = valid_reg;
  assign bus.number_o = lfsr_reg;
  assign bus.busy_o   = busy_reg;
  assign bus.count_o  = count_reg;

endmodule

// File: tb/tb_rng_stream.sv
// Directed bench for rng_stream: 8-bit instances (no warm-up and 2-cycle
// warm-up) plus 64-bit instances stepping once and twice per advance.
module tb_rng_stream;

  logic clk;
  logic reset;

  int total_checks = 0;
  int pass_checks  = 0;

  rng_stream_if #(.WIDTH(8),  .CNT_W(16)) a_if ();
  rng_stream_if #(.WIDTH(8),  .CNT_W(16)) b_if ();
  rng_stream_if #(.WIDTH(64), .CNT_W(32)) c_if ();
  rng_stream_if #(.WIDTH(64), .CNT_W(32)) d_if ();

  rng_stream #(.WIDTH(8), .TAPS(8'hB8), .STEPS(1), .WARMUP(0),
               .ZERO_SUB(8'hFF), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if.master));

  rng_stream #(.WIDTH(8), .TAPS(8'hB8), .STEPS(1), .WARMUP(2),
               .ZERO_SUB(8'hFF), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .bus(b_if.master));

  rng_stream #(.WIDTH(64), .TAPS(64'hD800000000000000), .STEPS(1), .WARMUP(0),
               .ZERO_SUB('1), .CNT_W(32)) dut_c (
    .clk(clk), .reset(reset), .bus(c_if.master));

  rng_stream #(.WIDTH(64), .TAPS(64'hD800000000000000), .STEPS(2), .WARMUP(0),
               .ZERO_SUB('1), .CNT_W(32)) dut_d (
    .clk(clk), .reset(reset), .bus(d_if.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] exp_words [6] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};

  task automatic test_reset();
    reset = 1'b0;
    #12;
    total_checks++;
    if (a_if.valid_o !== 1'b0 || a_if.number_o !== 8'h00 || a_if.count_o !== 16'h0 || a_if.busy_o !== 1'b0)
      $display("FAIL reset_a: valid=%b number=%h count=%0d busy=%b required 0/00/0/0",
               a_if.valid_o, a_if.number_o, a_if.count_o, a_if.busy_o);
    else pass_checks++;
    total_checks++;
    if (b_if.valid_o !== 1'b0 || b_if.busy_o !== 1'b0 || c_if.number_o !== 64'h0 || d_if.count_o !== 32'h0)
      $display("FAIL reset_bcd: b.valid=%b b.busy=%b c.number=%h d.count=%0d required all zero",
               b_if.valid_o, b_if.busy_o, c_if.number_o, d_if.count_o);
    else pass_checks++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_sequence();
    @(negedge clk);
    a_if.seed_i = 8'h01; a_if.loadseed_i = 1'b1; a_if.ready_i = 1'b1;
    @(negedge clk);
    a_if.loadseed_i = 1'b0;
    total_checks++;
    if (a_if.valid_o !== 1'b0)
      $display("FAIL seq_load_valid: valid=%b required 0", a_if.valid_o);
    else pass_checks++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      $display("txn seq word %0d: valid=%b number=%h count=%0d", i, a_if.valid_o, a_if.number_o, a_if.count_o);
      total_checks++;
      if (a_if.valid_o !== 1'b1 || a_if.number_o !== exp_words[i] || a_if.count_o !== 16'(i))
        $display("FAIL seq_word%0d: valid=%b number=%h count=%0d required 1/%h/%0d",
                 i, a_if.valid_o, a_if.number_o, a_if.count_o, exp_words[i], i);
      else pass_checks++;
    end
  endtask

  task automatic test_warmup();
    @(negedge clk);
    b_if.seed_i = 8'h01; b_if.loadseed_i = 1'b1; b_if.ready_i = 1'b1;
    @(negedge clk);
    b_if.loadseed_i = 1'b0;
    total_checks++;
    if (b_if.busy_o !== 1'b1 || b_if.valid_o !== 1'b0)
      $display("FAIL warmup_c1: busy=%b valid=%b required 1/0", b_if.busy_o, b_if.valid_o);
    else pass_checks++;
    @(negedge clk);
    total_checks++;
    if (b_if.busy_o !== 1'b1 || b_if.valid_o !== 1'b0)
      $display("FAIL warmup_c2: busy=%b valid=%b required 1/0", b_if.busy_o, b_if.valid_o);
    else pass_checks++;
    @(negedge clk);
    total_checks++;
    if (b_if.busy_o !== 1'b0 || b_if.valid_o !== 1'b0)
      $display("FAIL warmup_c3: busy=%b valid=%b required 0/0", b_if.busy_o, b_if.valid_o);
    else pass_checks++;
    @(negedge clk);
    $display("txn warmup first word: valid=%b number=%h count=%0d", b_if.valid_o, b_if.number_o, b_if.count_o);
    total_checks++;
    if (b_if.valid_o !== 1'b1 || b_if.number_o !== 8'h5C || b_if.count_o !== 16'd0)
      $display("FAIL warmup_first: valid=%b number=%h count=%0d required 1/5c/0",
               b_if.valid_o, b_if.number_o, b_if.count_o);
    else pass_checks++;
    b_if.ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    a_if.seed_i = 8'h01; a_if.loadseed_i = 1'b1; a_if.ready_i = 1'b1;
    @(negedge clk);
    a_if.loadseed_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a_if.ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total_checks++;
      if (a_if.valid_o !== 1'b1 || a_if.number_o !== 8'hB8 || a_if.count_o !== 16'd1)
        $display("FAIL stall_%0d: valid=%b number=%h count=%0d required 1/b8/1",
                 i, a_if.valid_o, a_if.number_o, a_if.count_o);
      else pass_checks++;
    end
    a_if.ready_i = 1'b1;
    @(negedge clk);
    $display("txn resume: number=%h count=%0d", a_if.number_o, a_if.count_o);
    total_checks++;
    if (a_if.number_o !== 8'h5C || a_if.count_o !== 16'd2)
      $display("FAIL stall_resume: number=%h count=%0d required 5c/2", a_if.number_o, a_if.count_o);
    else pass_checks++;
  endtask

  task automatic test_zero_seed();
    bit ok_period;
    @(negedge clk);
    a_if.seed_i = 8'h00; a_if.loadseed_i = 1'b1; a_if.ready_i = 1'b1;
    @(negedge clk);
    a_if.loadseed_i = 1'b0;
    @(negedge clk);
    total_checks++;
    if (a_if.valid_o !== 1'b1 || a_if.number_o !== 8'hFF || a_if.count_o !== 16'd0)
      $display("FAIL zero_first: valid=%b number=%h count=%0d required 1/ff/0",
               a_if.valid_o, a_if.number_o, a_if.count_o);
    else pass_checks++;
    @(negedge clk);
    total_checks++;
    if (a_if.number_o !== 8'hC7 || a_if.count_o !== 16'd1)
      $display("FAIL zero_second: number=%h count=%0d required c7/1", a_if.number_o, a_if.count_o);
    else pass_checks++;

    // Full period: 254 intermediate words never zero nor the seed, back to seed at 255.
    a_if.seed_i = 8'h01; a_if.loadseed_i = 1'b1;
    @(negedge clk);
    a_if.loadseed_i = 1'b0;
    @(negedge clk);
    ok_period = 1'b1;
    for (int i = 1; i < 255; i++) begin
      @(negedge clk);
      if (a_if.number_o === 8'h00 || a_if.number_o === 8'h01) ok_period = 1'b0;
    end
    total_checks++;
    if (!ok_period)
      $display("FAIL period_inner: a word inside the period was 00 or 01, required neither");
    else pass_checks++;
    @(negedge clk);
    $display("txn period end: number=%h count=%0d", a_if.number_o, a_if.count_o);
    total_checks++;
    if (a_if.number_o !== 8'h01 || a_if.count_o !== 16'd255)
      $display("FAIL period_end: number=%h count=%0d required 01/255", a_if.number_o, a_if.count_o);
    else pass_checks++;
  endtask

  task automatic test_reload_reset();
    a_if.ready_i = 1'b0;
    repeat (3) @(negedge clk);
    a_if.seed_i = 8'h17; a_if.loadseed_i = 1'b1; a_if.ready_i = 1'b1;
    @(negedge clk);
    a_if.loadseed_i = 1'b0;
    total_checks++;
    if (a_if.valid_o !== 1'b0 || a_if.count_o !== 16'd0 || a_if.number_o !== 8'h17)
      $display("FAIL reload_edge: valid=%b count=%0d number=%h required 0/0/17",
               a_if.valid_o, a_if.count_o, a_if.number_o);
    else pass_checks++;
    @(negedge clk);
    total_checks++;
    if (a_if.valid_o !== 1'b1 || a_if.number_o !== 8'h17 || a_if.count_o !== 16'd0)
      $display("FAIL reload_first: valid=%b number=%h count=%0d required 1/17/0",
               a_if.valid_o, a_if.number_o, a_if.count_o);
    else pass_checks++;
    b_if.seed_i = 8'h01; b_if.loadseed_i = 1'b1;
    @(negedge clk);
    b_if.loadseed_i = 1'b0;
    total_checks++;
    if (a_if.number_o !== 8'hB3 || a_if.count_o !== 16'd1 || b_if.busy_o !== 1'b1)
      $display("FAIL reload_second: a.number=%h a.count=%0d b.busy=%b required b3/1/1",
               a_if.number_o, a_if.count_o, b_if.busy_o);
    else pass_checks++;
    #2 reset = 1'b0;
    #1;
    total_checks++;
    if (a_if.valid_o !== 1'b0 || a_if.number_o !== 8'h00 || a_if.count_o !== 16'd0 ||
        b_if.busy_o !== 1'b0 || b_if.number_o !== 8'h00)
      $display("FAIL async_reset: a.valid=%b a.number=%h a.count=%0d b.busy=%b b.number=%h required zeros",
               a_if.valid_o, a_if.number_o, a_if.count_o, b_if.busy_o, b_if.number_o);
    else pass_checks++;
    @(negedge clk);
    reset = 1'b1;
    b_if.ready_i = 1'b1;
    repeat (3) @(negedge clk);
    total_checks++;
    if (a_if.valid_o !== 1'b0 || a_if.number_o !== 8'h00 || a_if.count_o !== 16'd0 ||
        b_if.valid_o !== 1'b0 || b_if.busy_o !== 1'b0)
      $display("FAIL idle_hold: a.valid=%b a.number=%h a.count=%0d b.valid=%b b.busy=%b required zeros",
               a_if.valid_o, a_if.number_o, a_if.count_o, b_if.valid_o, b_if.busy_o);
    else pass_checks++;
    b_if.ready_i = 1'b0;
  endtask

  task automatic test_wide();
    @(negedge clk);
    c_if.seed_i = 64'h1; c_if.loadseed_i = 1'b1; c_if.ready_i = 1'b1;
    d_if.seed_i = 64'h1; d_if.loadseed_i = 1'b1; d_if.ready_i = 1'b1;
    @(negedge clk);
    c_if.loadseed_i = 1'b0; d_if.loadseed_i = 1'b0;
    @(negedge clk);
    total_checks++;
    if (c_if.number_o !== 64'h1 || d_if.number_o !== 64'h1 || c_if.valid_o !== 1'b1)
      $display("FAIL wide_first: c=%h d=%h valid=%b required 1/1/1", c_if.number_o, d_if.number_o, c_if.valid_o);
    else pass_checks++;
    @(negedge clk);
    $display("txn wide second: c=%h d=%h", c_if.number_o, d_if.number_o);
    total_checks++;
    if (c_if.number_o !== 64'hD800000000000000 || d_if.number_o !== 64'h6C00000000000000)
      $display("FAIL wide_second: c=%h d=%h required d800000000000000/6c00000000000000",
               c_if.number_o, d_if.number_o);
    else pass_checks++;
    @(negedge clk);
    total_checks++;
    if (c_if.number_o !== 64'h6C00000000000000 || d_if.number_o !== 64'h1B00000000000000 ||
        d_if.count_o !== 32'd2)
      $display("FAIL wide_third: c=%h d=%h d.count=%0d required 6c00000000000000/1b00000000000000/2",
               c_if.number_o, d_if.number_o, d_if.count_o);
    else pass_checks++;
  endtask

  initial begin
    a_if.loadseed_i = 1'b0; a_if.seed_i = '0; a_if.ready_i = 1'b0;
    b_if.loadseed_i = 1'b0; b_if.seed_i = '0; b_if.ready_i = 1'b0;
    c_if.loadseed_i = 1'b0; c_if.seed_i = '0; c_if.ready_i = 1'b0;
    d_if.loadseed_i = 1'b0; d_if.seed_i = '0; d_if.ready_i = 1'b0;
    test_reset();
    test_sequence();
    test_warmup();
    test_backpressure();
    test_zero_seed();
    test_reload_reset();
    test_wide();
    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/rng_stream.md
Name: rng_stream

Overview:
- Parametrised successor to the 64-bit seeded random number generator.
- Galois LFSR pseudo-random source with generic width, tap mask and steps-per-output.
- Adds a post-seed warm-up phase, zero-seed protection, a valid/ready output handshake and a delivered-word counter.
- Feeds random words to consumers such as test stimulus, scramblers and arbitration jitter, which stall it via ready_i.

Parameters:
- WIDTH, 64: state and output width in bits; must be at least 2.
- TAPS, 64'hD800000000000000: Galois right-shift feedback mask (x^64+x^63+x^61+x^60+1); WIDTH bits wide.
- STEPS, 1: LFSR steps unrolled per advance, range 1..WIDTH.
- WARMUP, 4: number of advances after a seed load before the first word is offered; 0 is allowed.
- ZERO_SUB, all ones: state substituted when the loaded seed is zero; must be nonzero.
- CNT_W, 32: width of the delivered-word counter.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-low reset. Assertion takes effect immediately; deassertion is synchronous to clk by the system.
- loadseed_i, in, 1: load seed_i on this edge and restart.
- seed_i, in, WIDTH: seed value.
- ready_i, in, 1: consumer accepts number_o.
- valid_o, out, 1: number_o holds a fresh word.
- number_o, out, WIDTH: current random word, which equals the LFSR state.
- busy_o, out, 1: high while in WARMUP.
- count_o, out, CNT_W: words delivered since the last seed load.

Behaviour:
- Step function f(s): if s[0]==1 then (s>>1)^TAPS, else s>>1.
- Advance: apply f STEPS times combinationally within one cycle.
- FSM has three states: IDLE, WARMUP, RUN.

Reset (reset==0, async):
- FSM=IDLE, state=0, valid_o=0, busy_o=0, count_o=0, number_o=0.

IDLE:
- Outputs are held.
- loadseed_i=1 loads the seed as described below.

Seed load (loadseed_i=1 at an edge, in any state):
- state <= (seed_i==0) ? ZERO_SUB : seed_i.
- count_o <= 0, warm-up counter <= 0, valid_o <= 0.
- FSM <= WARMUP if WARMUP>0, else RUN.
- A seed load has priority over any handshake on that edge. A word offered on that edge is NOT counted as delivered, even if ready_i=1.

WARMUP:
- Every edge: state <= advance(state), counter++.
- Once WARMUP advances have completed, FSM <= RUN.
- valid_o=0 and busy_o=1 throughout.

RUN:
- valid_o=1; number_o = state.
- On an edge with ready_i=1 (fire): state <= advance(state) and count_o <= count_o+1, wrapping modulo 2^CNT_W.
- ready_i=0: state and number_o are held stable (no advance while stalled).
- valid_o stays high; back-to-back fires deliver one word per cycle.

Latency from the load edge:
- First valid word appears WARMUP+1 cycles after the load edge.
- That first word is the seed advanced WARMUP times.

Other rules:
- The state never reaches 0 for a nonzero seed; a zero seed is replaced by ZERO_SUB.
- ready_i is ignored outside RUN.
- Reset asserted mid-warm-up or mid-stall returns to IDLE at once; a new seed load is then required.

Test Plan:
1. WIDTH=8, TAPS=8'hB8, STEPS=1, WARMUP=0. Load seed 8'h01, hold ready_i=1 -> valid_o rises on the cycle after load; number_o sequence 01, B8, 5C, 2E, 17, B3; count_o increments 0..5.
2. Same config, WARMUP=2, seed 8'h01 -> busy_o high for 2 cycles; valid_o rises 3 cycles after the load edge with number_o=5C; count_o=0.
3. Backpressure: in RUN with number_o=B8, drop ready_i for 5 cycles -> number_o stays B8 and count_o is unchanged; raise ready_i -> next word 5C.
4. Zero seed: WIDTH=8, ZERO_SUB=8'hFF, seed 0, WARMUP=0 -> first word FF, second word 7F^B8=C7. Also check a maximal TAPS run returns to the seed after exactly 255 fires.
5. Reload and reset: assert loadseed_i (seed 8'h17) during a stall with ready_i=1 -> that edge is not counted; valid_o drops; first word 17; count_o=0. Then assert reset asynchronously mid-RUN -> all outputs zero immediately and FSM stays IDLE until the next load.
6. Default 64-bit, STEPS=1, WARMUP=0, seed 64'h0000000000000001 -> words 0000000000000001, D800000000000000, 6C00000000000000. Repeat with STEPS=2 -> second word 6C00000000000000.
